ps2_dir_queue: RTL and testbench
================================

// Module: ps2_dir_queue
// PURPOSE
//  Decodes PS/2 set-2 scan bytes from keyboard (key/rdy) into snake commands: direction moves, start, pause toggle.
//  Buffers direction requests in a small FIFO, applying one per game step, so fast key bursts between ticks are kept.
//  Sits between keyboard and snake_field; cur_dir drives snake_field.snake_dir, step = tick & is_running.
// PARAMETERS
//  DEPTH        4      direction FIFO entries; power of two, >= 2
//  INIT_DIR     2'd1   direction after reset/flush (0 up, 1 right, 2 down, 3 left)
// PORTS
//  clk           in   1              system clock
//  rst           in   1              synchronous, active-high reset
//  key           in   8              scan byte from keyboard
//  key_rdy       in   1              1-cycle strobe: key valid
//  step          in   1              game step; pops FIFO head into cur_dir
//  flush         in   1              empty FIFO, cur_dir <= INIT_DIR, decoder -> IDLE
//  cur_dir       out  2              direction currently applied
//  q_count       out  $clog2(DEPTH+1) entries queued
//  start_p       out  1              1-cycle pulse: Enter (5A) make
//  pause_p       out  1              1-cycle pulse: Space (29) make
//  overflow_p    out  1              1-cycle pulse: valid direction dropped, FIFO full
// BEHAVIOUR
//  Reset: cur_dir=INIT_DIR, q_count=0, start_p=pause_p=overflow_p=0, decoder IDLE, FIFO pointers 0.
//  Decoder FSM, advances only on key_rdy: IDLE, EXT, BRK, EXT_BRK.
//   E0 from any state -> EXT. F0: IDLE->BRK, EXT->EXT_BRK, BRK/EXT_BRK stay.
//   BRK/EXT_BRK + other byte: discarded (key release), -> IDLE.
//   EXT + 75/74/72/6B: direction 0/1/2/3 request, -> IDLE; other byte ignored, -> IDLE.
//   IDLE + 5A: start_p; IDLE + 29: pause_p; other unmapped byte ignored.
//  Command pulses and FIFO push take effect cycle after key_rdy (1-cycle latency).
//  Push filter: ref = last pushed entry if q_count>0, else cur_dir.
//   Request dropped silently if req == ref or req == ref ^ 2'b10 (no repeat, no reversal).
//   Accepted with q_count==DEPTH: dropped, overflow_p=1.
//  Pop: step && q_count>0 -> cur_dir <= head, q_count-1 next cycle; step with empty FIFO: no change.
//  Push + pop same cycle, non-empty: both performed, q_count unchanged; full: pop frees slot, push accepted,
//   no overflow; filter ref still from pre-pop state.
//  Push + pop same cycle, empty: push queued, cur_dir unchanged, q_count=1.
//  Pointers wrap modulo DEPTH; q_count never exceeds DEPTH.
//  flush: priority over push/pop this cycle; key byte same cycle discarded; outputs pulse-free.
//  rst priority over flush. Reset mid-sequence (after E0/F0) returns to IDLE; next byte decoded fresh.
// CONFIGURATION
//  WASD_EN defined: in IDLE, make codes 1D/23/1B/1C (W/D/S/A) also request 0/1/2/3, same filter/FIFO path.
//   Break of those (F0 xx) discarded as usual.
//  WASD_EN undefined: 1D/23/1B/1C ignored in IDLE; only extended arrows move.
// TESTING
//  Reset, no input -> cur_dir=1, q_count=0, all pulses 0 for 100 cycles.
//  Bytes E0,75 then step -> q_count=1 after 75; after step cur_dir=0, q_count=0.
//  cur_dir=1, push left (E0 6B) -> dropped, q_count=0; push right (E0 74) -> dropped.
//  Queue up,left,down,right (DEPTH=4) from cur_dir=1 -> q_count=4; then up -> overflow_p=1, q_count=4;
//   four steps -> cur_dir 0,3,2,1 in order.
//  E0,F0,75 (release) and F0,29 -> no push, no pause_p; 29 alone -> pause_p one cycle; 5A -> start_p.
//  Step and E0-75 push same cycle with q_count=0 -> cur_dir=1, q_count=1; flush with q_count=3 -> q_count=0, cur_dir=1.
//  WASD_EN on: 1D -> up queued; off: 1D -> q_count stays 0.

Source files
------------

// File: rtl/ps2_dir_queue_if.sv
// Keyboard-to-snake command bus: scan byte input, step/flush control, and the decoded direction/pulse outputs.
interface ps2_dir_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    key;
    logic          key_rdy;
    logic          step;
    logic          flush;
    logic [1:0]    cur_dir;
    logic [CW-1:0] q_count;
    logic          start_p;
    logic          pause_p;
    logic          overflow_p;

    modport master (
        output key, key_rdy, step, flush,
        input  cur_dir, q_count, start_p, pause_p, overflow_p
    );

    modport slave (
        input  key, key_rdy, step, flush,
        output cur_dir, q_count, start_p, pause_p, overflow_p
    );
endinterface

// File: rtl/ps2_dir_queue.sv
// PS/2 set-2 decoder feeding a filtered direction FIFO for the snake game; one queued turn is applied per step.
// Optional macro WASD_EN adds W/D/S/A make codes as direction requests alongside the extended arrow keys.
module ps2_dir_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'd1
) (
    input logic            clk,
    input logic            rst,
    ps2_dir_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_SPACE = 8'h29;
`ifdef WASD_EN
    localparam logic [7:0] K_W = 8'h1D;
    localparam logic [7:0] K_D = 8'h23;
    localparam logic [7:0] K_S = 8'h1B;
    localparam logic [7:0] K_A = 8'h1C;
`endif

    logic [1:0]    state_q, state_d;
    logic [1:0]    cur_dir_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          start_q, start_d;
    logic          pause_q, pause_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    mem_q [DEPTH];

    logic          req_vld;
    logic [1:0]    req_dir;
    logic [PW-1:0] last_ptr;
    logic [1:0]    ref_dir;
    logic          is_full;
    logic          legal;
    logic          pop_en;
    logic          push_en;

    // Prefix tracker: E0 marks an extended code, F0 marks a release; the byte after F0 is swallowed.
    always_comb begin
        state_d = state_q;
        req_vld = 1'b0;
        req_dir = 2'd0;
        start_d = 1'b0;
        pause_d = 1'b0;
        if (bus.key_rdy) begin
            if (bus.key == K_EXT) begin
                state_d = ST_EXT;
            end else if (bus.key == K_BRK) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end
            end else begin
                state_d = ST_IDLE;
                case (state_q)
                    ST_EXT: begin
                        case (bus.key)
                            K_UP:    begin req_vld = 1'b1; req_dir = 2'd0; end
                            K_RIGHT: begin req_vld = 1'b1; req_dir = 2'd1; end
                            K_DOWN:  begin req_vld = 1'b1; req_dir = 2'd2; end
                            K_LEFT:  begin req_vld = 1'b1; req_dir = 2'd3; end
                            default: ;
                        endcase
                    end
                    ST_IDLE: begin
                        case (bus.key)
                            K_ENTER: start_d = 1'b1;
                            K_SPACE: pause_d = 1'b1;
`ifdef WASD_EN
                            K_W:     begin req_vld = 1'b1; req_dir = 2'd0; end
                            K_D:     begin req_vld = 1'b1; req_dir = 2'd1; end
                            K_S:     begin req_vld = 1'b1; req_dir = 2'd2; end
                            K_A:     begin req_vld = 1'b1; req_dir = 2'd3; end
`endif
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // The filter compares against the direction the snake will have when this request is reached,
    // i.e. the newest queued entry, falling back to the applied direction when nothing is queued.
    always_comb begin
        last_ptr = wr_ptr_q - PW'(1);
        ref_dir  = (count_q != '0) ? mem_q[last_ptr] : cur_dir_q;
        is_full  = (count_q == CW'(DEPTH));
        pop_en   = bus.step && (count_q != '0);
        legal    = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10));
        push_en  = legal && (!is_full || pop_en);
        ovf_d    = legal && is_full && !pop_en;
    end

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q   <= ST_IDLE;
            cur_dir_q <= INIT_DIR;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pause_q <= pause_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                cur_dir_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_en && !rst && !bus.flush) begin
            mem_q[wr_ptr_q] <= req_dir;
        end
    end

    assign bus.cur_dir    = cur_dir_q;
    assign bus.q_count    = count_q;
    assign bus.start_p    = start_q;
    assign bus.pause_p    = pause_q;
    assign bus.overflow_p = ovf_q;
endmodule

// File: tb/tb_ps2_dir_queue.sv
// Scoreboard bench for ps2_dir_queue: a driver pushes per-cycle expectations from a queue-based model, a monitor checks them.
module tb_ps2_dir_queue;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_DIR = 2'd1;
    localparam int         CW       = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_dir_queue_if #(.DEPTH(DEPTH)) bus ();
    ps2_dir_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT_DIR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [1:0]    dir;
        logic [CW-1:0] cnt;
        logic          st;
        logic          pa;
        logic          ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: applied direction, list of pending turns, and two prefix flags.
    logic [1:0] m_dir;
    logic [1:0] m_q[$];
    bit         m_ext, m_brk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model(input logic [7:0] k, input bit rdy, input bit stp, input bit fl, input bit rs);
        exp_t       e;
        bit         rv, st, pa, ov, pop;
        logic [1:0] rd, rf;
        rv = 0; st = 0; pa = 0; ov = 0; rd = 2'd0;
        if (rs || fl) begin
            m_dir = INIT_DIR;
            m_q.delete();
            m_ext = 0;
            m_brk = 0;
        end else begin
            if (rdy) begin
                if (k == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (k == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    if (m_brk) begin
                        rv = 0;
                    end else if (m_ext) begin
                        if (k == 8'h75) begin rv = 1; rd = 2'd0; end
                        if (k == 8'h74) begin rv = 1; rd = 2'd1; end
                        if (k == 8'h72) begin rv = 1; rd = 2'd2; end
                        if (k == 8'h6B) begin rv = 1; rd = 2'd3; end
                    end else begin
                        st = (k == 8'h5A);
                        pa = (k == 8'h29);
`ifdef WASD_EN
                        if (k == 8'h1D) begin rv = 1; rd = 2'd0; end
                        if (k == 8'h23) begin rv = 1; rd = 2'd1; end
                        if (k == 8'h1B) begin rv = 1; rd = 2'd2; end
                        if (k == 8'h1C) begin rv = 1; rd = 2'd3; end
`endif
                    end
                    m_ext = 0; m_brk = 0;
                end
            end
            pop = stp && (m_q.size() > 0);
            rf  = (m_q.size() > 0) ? m_q[$] : m_dir;
            if (pop) m_dir = m_q.pop_front();
            // A turn is legal if it is neither a repeat nor a U-turn relative to the last planned heading.
            if (rv && rd != rf && rd != (rf ^ 2'b10)) begin
                if (m_q.size() < DEPTH) m_q.push_back(rd);
                else ov = 1;
            end
        end
        e.dir = m_dir;
        e.cnt = CW'(m_q.size());
        e.st  = st;
        e.pa  = pa;
        e.ov  = ov;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] k, input bit rdy, input bit stp, input bit fl, input bit rs);
        @(posedge clk);
        #2;
        bus.key     = k;
        bus.key_rdy = rdy;
        bus.step    = stp;
        bus.flush   = fl;
        rst         = rs;
        model(k, rdy, stp, fl, rs);
    endtask

    task automatic key1(input logic [7:0] k);
        cyc(k, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cur_dir",    8'(bus.cur_dir),    8'(e.dir));
                chk("q_count",    8'(bus.q_count),    8'(e.cnt));
                chk("start_p",    8'(bus.start_p),    8'(e.st));
                chk("pause_p",    8'(bus.pause_p),    8'(e.pa));
                chk("overflow_p", 8'(bus.overflow_p), 8'(e.ov));
            end
        end
    end

    initial begin : driver
        logic [7:0] codes [12];
        logic [7:0] k;
        int         idx;
        int         budget;
        codes = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
                  8'h5A, 8'h29, 8'h1D, 8'h23, 8'h1B, 8'h1C};
        bus.key = 8'h00; bus.key_rdy = 1'b0; bus.step = 1'b0; bus.flush = 1'b0;

        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(100);

        key1(8'hE0); key1(8'h75);
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        key1(8'hE0); key1(8'h6B);
        key1(8'hE0); key1(8'h74);

        key1(8'hE0); key1(8'h75);
        key1(8'hE0); key1(8'h6B);
        key1(8'hE0); key1(8'h72);
        key1(8'hE0); key1(8'h74);
        key1(8'hE0); key1(8'h75);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        key1(8'hE0); key1(8'hF0); key1(8'h75);
        key1(8'hF0); key1(8'h29);
        key1(8'h29); idle(1);
        key1(8'h5A); idle(1);

        cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        key1(8'hE0);
        cyc(8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
        key1(8'hE0); key1(8'h6B);
        key1(8'hE0); key1(8'h75);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        key1(8'hE0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        key1(8'h29);
        key1(8'h1D); idle(2);

        for (int i = 0; i < 3000; i++) begin
            idx = $urandom_range(0, 12);
            if (idx == 12) k = 8'($urandom);
            else k = codes[idx];
            cyc(k, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0));
        end

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            #3;
            budget--;
        end
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
